// File: rtl/jesd204_pattern_align_lock.sv
// jesd204_pattern_align_lock: K28.5 comma symbol aligner with SEARCH/CHECK/LOCKED hysteresis
module jesd204_pattern_align_lock #(
    parameter int         DATA_PATH_WIDTH = 4,
    parameter logic [9:0] PATTERN_P       = 10'b1010000011,
    parameter logic [9:0] PATTERN_N       = 10'b0101111100,
    parameter int         LOCK_COUNT      = 4,
    parameter int         UNLOCK_COUNT    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         patternalign_en,
    input  logic [10*DATA_PATH_WIDTH-1:0] in_data,
    output logic [10*DATA_PATH_WIDTH-1:0] out_data,
    output logic                         aligned,
    output logic [3:0]                   bitshift
);
    localparam int W    = 10 * DATA_PATH_WIDTH;
    localparam int MAXC = LOCK_COUNT > UNLOCK_COUNT ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [1:0] SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2;
    localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT), UNLOCK_C = CW'(UNLOCK_COUNT), MAX_C = CW'(MAXC);

    logic [W-1:0]    r0, r1, shifted;
    logic [2*W-1:0]  window;
    logic [9:0]      hits;
    logic [3:0]      first_hit, shift_nx;
    logic            word_match;
    logic [1:0]      state, state_nx;
    logic [CW-1:0]   match_cnt, match_nx, miss_cnt, miss_nx;

    assign window  = {r0, r1};
    assign shifted = W'(window >> bitshift);

    for (genvar k = 0; k < 10; k++) begin : g_hit
        assign hits[k] = (window[k +: 10] == PATTERN_P) || (window[k +: 10] == PATTERN_N);
    end

    // lowest candidate offset holding a comma
    always_comb begin
        first_hit = '0;
        for (int k = 9; k >= 0; k--) if (hits[k]) first_hit = 4'(k);
    end

    // every symbol at the applied offset must be a comma of either disparity
    always_comb begin
        word_match = 1'b1;
        for (int j = 0; j < DATA_PATH_WIDTH; j++)
            if (shifted[10*j +: 10] != PATTERN_P && shifted[10*j +: 10] != PATTERN_N) word_match = 1'b0;
    end

    // lock state machine with saturating match/miss counters
    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        miss_nx  = miss_cnt;
        shift_nx = bitshift;
        if (state == SEARCH) begin
            if (patternalign_en && |hits) begin
                shift_nx = first_hit;
                match_nx = CW'(1);
                miss_nx  = '0;
                state_nx = LOCK_COUNT == 1 ? LOCKED : CHECK;
            end
        end else if (state == CHECK) begin
            if (patternalign_en) begin
                if (word_match) begin
                    match_nx = match_cnt == MAX_C ? match_cnt : match_cnt + CW'(1);
                    if (match_nx == LOCK_C) begin
                        state_nx = LOCKED;
                        miss_nx  = '0;
                    end
                end else begin
                    state_nx = SEARCH;
                end
            end
        end else if (state == LOCKED) begin
            if (patternalign_en) begin
                if (word_match) begin
                    miss_nx = '0;
                end else begin
                    miss_nx = miss_cnt == MAX_C ? miss_cnt : miss_cnt + CW'(1);
                    if (miss_nx == UNLOCK_C) state_nx = SEARCH;
                end
            end
        end else begin
            state_nx = SEARCH;
        end
    end

    // input pipeline, aligned output register and state update
    always_ff @(posedge clk) begin
        if (reset) begin
            r0        <= '0;
            r1        <= '0;
            out_data  <= '0;
            aligned   <= 1'b0;
            bitshift  <= '0;
            state     <= SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            r0        <= in_data;
            r1        <= r0;
            out_data  <= shifted;
            aligned   <= state_nx == LOCKED;
            bitshift  <= shift_nx;
            state     <= state_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
        end
    end
endmodule

// File: tb/tb_jesd204_pattern_align_lock.sv
// tb_jesd204_pattern_align_lock: randomized bit-stream bench for the comma aligner, DPW=4 and DPW=1
module tb_jesd204_pattern_align_lock;
    localparam logic [9:0] P = 10'b1010000011;
    localparam logic [9:0] N = 10'b0101111100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [39:0] in4 = '0, out4;
    logic [9:0]  in1 = '0, out1;
    logic        al4, al1;
    logic [3:0]  bs4, bs1;

    int passes = 0;
    int total  = 0;

    bit q4[$];
    bit q1[$];

    int wid[2] = '{40, 10};
    int lck[2] = '{4, 1};
    int ulk[2] = '{4, 4};
    logic [79:0] mr0[2], mr1[2], mout[2];
    int  msh[2], mrun[2], mmiss[2];
    bit  mlk[2], mck[2];

    always #5 clk = ~clk;

    jesd204_pattern_align_lock u4 (
        .clk(clk), .reset(rst), .patternalign_en(en), .in_data(in4),
        .out_data(out4), .aligned(al4), .bitshift(bs4)
    );

    jesd204_pattern_align_lock #(.DATA_PATH_WIDTH(1), .LOCK_COUNT(1)) u1 (
        .clk(clk), .reset(rst), .patternalign_en(en), .in_data(in1),
        .out_data(out1), .aligned(al1), .bitshift(bs1)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [9:0] sym(input int kind);
        if (kind == 0) return $urandom_range(0, 1) ? P : N;
        return 10'($urandom);
    endfunction

    task automatic push(input int u, input logic [9:0] s);
        for (int i = 0; i < 10; i++) if (u == 0) q4.push_back(s[i]); else q1.push_back(s[i]);
    endtask

    task automatic push_both(input logic [9:0] s);
        push(0, s);
        push(1, s);
    endtask

    task automatic slip(input int n, input bit rnd);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 1'($urandom) : 1'b0;
            q4.push_back(b);
            q1.push_back(b);
        end
    endtask

    // reference: the raw bit stream seen over the last two words, judged by the lock rules
    task automatic model_step(input int u, input logic [79:0] din, input bit en_i, input bit r);
        logic [159:0] win, m;
        logic [9:0]   c;
        int           k;
        bit           wm;
        if (r) begin
            mr0[u] = '0; mr1[u] = '0; mout[u] = '0;
            msh[u] = 0; mrun[u] = 0; mmiss[u] = 0; mlk[u] = 0; mck[u] = 0;
            return;
        end
        m   = (160'd1 << wid[u]) - 160'd1;
        win = ({80'd0, mr0[u]} << wid[u]) | {80'd0, mr1[u]};
        mout[u] = 80'((win >> msh[u]) & m);
        k = -1;
        for (int i = 9; i >= 0; i--) begin
            c = 10'(win >> i);
            if (c == P || c == N) k = i;
        end
        wm = 1;
        for (int j = 0; j < wid[u] / 10; j++) begin
            c = 10'(win >> (msh[u] + 10 * j));
            if (!(c == P || c == N)) wm = 0;
        end
        if (mlk[u]) begin
            if (en_i) begin
                if (wm) mmiss[u] = 0;
                else begin
                    mmiss[u]++;
                    if (mmiss[u] == ulk[u]) mlk[u] = 0;
                end
            end
        end else if (mck[u]) begin
            if (en_i) begin
                if (wm) begin
                    mrun[u]++;
                    if (mrun[u] == lck[u]) begin mck[u] = 0; mlk[u] = 1; mmiss[u] = 0; end
                end else mck[u] = 0;
            end
        end else if (en_i && k >= 0) begin
            msh[u]  = k;
            mrun[u] = 1;
            if (lck[u] == 1) begin mlk[u] = 1; mmiss[u] = 0; end
            else mck[u] = 1;
        end
        mr1[u] = mr0[u];
        mr0[u] = din & 80'(m);
    endtask

    task automatic tick(input int kind, input bit r);
        logic [79:0] d4, d1;
        while (q4.size() < 40) push(0, sym(kind));
        while (q1.size() < 10) push(1, sym(kind));
        d4 = '0;
        d1 = '0;
        for (int i = 0; i < 40; i++) d4[i] = q4.pop_front();
        for (int i = 0; i < 10; i++) d1[i] = q1.pop_front();
        rst = r;
        in4 = d4[39:0];
        in1 = d1[9:0];
        @(posedge clk);
        model_step(0, d4, en, r);
        model_step(1, d1, en, r);
        #1;
        check("out4", {40'd0, out4}, mout[0]);
        check("al4", 80'(al4), 80'(mlk[0]));
        check("bs4", 80'(bs4), 80'(msh[0]));
        check("out1", {70'd0, out1}, mout[1]);
        check("al1", 80'(al1), 80'(mlk[1]));
        check("bs1", 80'(bs1), 80'(msh[1]));
    endtask

    task automatic do_reset();
        q4.delete();
        q1.delete();
        tick(0, 1);
        rst = 1'b0;
        check("rst_al4", 80'(al4), 80'd0);
        check("rst_bs4", 80'(bs4), 80'd0);
        check("rst_out4", {40'd0, out4}, 80'd0);
        check("rst_al1", 80'(al1), 80'd0);
        check("rst_bs1", 80'(bs1), 80'd0);
        check("rst_out1", {70'd0, out1}, 80'd0);
    endtask

    task automatic acquire(input int s);
        int t4, t1;
        do_reset();
        slip(s, 0);
        t4 = 0;
        t1 = 0;
        for (int t = 1; t <= 8; t++) begin
            tick(0, 0);
            if (al4 && t4 == 0) t4 = t;
            if (al1 && t1 == 0) t1 = t;
        end
        check("lock_time4", 80'(t4 >= 1 && t4 <= 7), 80'd1);
        check("lock_time1", 80'(t1 >= 1 && t1 <= 4), 80'd1);
    endtask

    initial begin
        logic [3:0] held4, held1;
        en = 1'b1;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            acquire(s);
            for (int i = 0; i < 6; i++) tick(0, 0);
            check("sweep_bs4", 80'(bs4), 80'(s));
            check("sweep_bs1", 80'(bs1), 80'(s));
            check("sweep_al4", 80'(al4), 80'd1);
            check("sweep_al1", 80'(al1), 80'd1);
        end
        acquire(3);
        slip(4, 1);
        for (int i = 0; i < 20; i++) tick(0, 0);
        check("reslip_al4", 80'(al4), 80'd1);
        held4 = bs4;
        held1 = bs1;
        push_both(10'h3ff);
        for (int i = 0; i < 10; i++) tick(0, 0);
        check("corrupt_bs4", 80'(bs4), 80'(held4));
        check("corrupt_bs1", 80'(bs1), 80'(held1));
        check("corrupt_al4", 80'(al4), 80'd1);
        en = 1'b0;
        for (int i = 0; i < 200; i++) tick(1, 0);
        check("frozen_bs4", 80'(bs4), 80'(held4));
        check("frozen_al4", 80'(al4), 80'd1);
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick(1, 0);
        acquire(5);
        do_reset();
        slip(5, 0);
        for (int i = 0; i < 3; i++) tick(0, 0);
        tick(1, 0);
        for (int i = 0; i < 10; i++) tick(0, 0);
        do_reset();
        slip(2, 0);
        for (int i = 0; i < 4; i++) tick(0, 0);
        do_reset();
        slip(8, 0);
        for (int i = 0; i < 10; i++) tick(0, 0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int roll;
            roll = $urandom_range(0, 99);
            if (roll < 3) do_reset();
            else if (roll < 8) slip($urandom_range(1, 9), 1);
            else if (roll < 12) push_both(10'h3ff);
            en = $urandom_range(0, 9) != 0;
            tick($urandom_range(0, 9) < 8 ? 0 : 1, 0);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/jesd204_pattern_align_lock.md
Name: jesd204_pattern_align_lock

Overview:
Multi-symbol soft-PCS comma aligner with a lock state machine. It takes a raw 10*DATA_PATH_WIDTH-bit deserialised stream with arbitrary bit slip and finds the 10-bit symbol boundary from K28.5 patterns (either disparity). It then emits symbol-aligned data and reports lock status with acquisition/loss hysteresis. It sits between the transceiver raw data output and the 8b10b decoder in the soft PCS receive path.

Parameters:
DATA_PATH_WIDTH, 4, number of 10-bit symbols per clock (1..8)
PATTERN_P, 10'b1010000011, comma pattern, positive disparity
PATTERN_N, 10'b0101111100, comma pattern, negative disparity
LOCK_COUNT, 4, consecutive fully-matching words required to declare lock (>=1)
UNLOCK_COUNT, 4, consecutive mismatching words in LOCKED required to drop lock (>=1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
patternalign_en  in  1  1 = search/track commas; 0 = freeze current offset
in_data  in  10*DATA_PATH_WIDTH  raw unaligned bits; bit 0 received first
out_data  out  10*DATA_PATH_WIDTH  symbol-aligned data; symbol i = bits [10i+9:10i]
aligned  out  1  lock status, registered
bitshift  out  4  current applied bit offset, 0..9

Behaviour:
- Pipeline:
  - r0 <= in_data; r1 <= r0.
  - window = {r0, r1}, r1 in the LSBs.
  - out_data <= window[bitshift +: 10*DATA_PATH_WIDTH].
  - Latency is 2 cycles from in_data to out_data for a fixed bitshift. A bitshift change affects out_data on the cycle after it updates.
- Match terms (combinational on window):
  - cand(k) = window[k +: 10], for k = 0..9.
  - hit(k) = cand(k) is PATTERN_P or PATTERN_N.
  - word_match = every symbol j of window[bitshift +: 10*DPW] is PATTERN_P or PATTERN_N. Each symbol is judged independently; disparity alternation is not checked.
- States: SEARCH, CHECK, LOCKED. A 2-bit state, a match counter, and a miss counter are all registered.
- SEARCH:
  - aligned = 0.
  - If patternalign_en is 1 and any hit(k) is set: bitshift <= lowest such k, match_cnt <= 1, go to CHECK. If LOCK_COUNT == 1, go directly to LOCKED instead.
  - Otherwise hold bitshift and stay in SEARCH.
- CHECK:
  - aligned = 0.
  - If patternalign_en is 0: hold state and counters.
  - If word_match: match_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED with miss_cnt <= 0.
  - If not word_match: go to SEARCH. bitshift holds until the next hit.
- LOCKED:
  - aligned = 1.
  - If patternalign_en is 0 (data phase): bitshift is frozen, no mismatch counting, stay in LOCKED.
  - If patternalign_en is 1 and word_match: miss_cnt <= 0.
  - If patternalign_en is 1 and not word_match: miss_cnt++. When the incremented value equals UNLOCK_COUNT, go to SEARCH and aligned deasserts on that same edge.
- Lock timing: aligned rises no later than LOCK_COUNT+3 cycles after a clean comma stream is first presented on in_data.
- Counters saturate, never wrap. Widths are clog2(max(LOCK_COUNT,UNLOCK_COUNT)+1).
- Reset:
  - out_data = 0, aligned = 0, bitshift = 0, state = SEARCH, counters = 0, r0 = r1 = 0.
  - Reset is valid in any state, including mid-CHECK, and wins over all other inputs.
- Glitch-free output: bitshift never changes while in LOCKED, so the out_data boundary stays stable while locked.

Test Plan:
1. DPW=4, continuous commas (random P/N per symbol), bit slip 3 -> bitshift=3 (or the equivalent lowest hit offset), aligned=1 within LOCK_COUNT+3 cycles, every out_data symbol is P or N thereafter.
2. Locked at slip 3, input slip changed to 7 -> aligned stays 1 for exactly UNLOCK_COUNT-1 mismatching words, falls on the UNLOCK_COUNT-th, then relocks with bitshift giving matching symbols.
3. Locked, one corrupted word (0x3FF in symbol 2) -> aligned stays 1, miss_cnt returns to 0, bitshift unchanged.
4. Locked, patternalign_en=0, random data for 200 cycles -> aligned stays 1, bitshift constant, out_data equals in_data realigned by bitshift with 2-cycle latency.
5. During CHECK, inject one non-comma word -> return to SEARCH, aligned never asserts before LOCK_COUNT clean words.
6. Assert reset mid-CHECK and mid-LOCKED -> next cycle aligned=0, bitshift=0, out_data=0; repeat all scenarios with DPW=1 and LOCK_COUNT=1, sweeping slip 0..9.
